// File: rtl/ycc_pkg.sv
// Shared types and constants for the RGB -> level-shifted 4:2:2 YCbCr sample path.
package ycc_pkg;

    localparam int SUM_W  = 19;
    localparam int WIDE_W = 10;
    localparam int SMP_W  = 8;

    // Coefficient sums, post-rounding intermediates, and final samples
    typedef logic signed [SUM_W-1:0]  ycc_sum_t;
    typedef logic signed [WIDE_W-1:0] ycc_wide_t;
    typedef logic signed [SMP_W-1:0]  ycc_sample_t;

    // Colour coefficients, scaled by 256
    localparam ycc_sum_t C_Y_R  =  19'sd77;
    localparam ycc_sum_t C_Y_G  =  19'sd150;
    localparam ycc_sum_t C_Y_B  =  19'sd29;
    localparam ycc_sum_t C_CB_R = -19'sd43;
    localparam ycc_sum_t C_CB_G = -19'sd85;
    localparam ycc_sum_t C_CB_B =  19'sd128;
    localparam ycc_sum_t C_CR_R =  19'sd128;
    localparam ycc_sum_t C_CR_G = -19'sd107;
    localparam ycc_sum_t C_CR_B = -19'sd21;

    // Half an LSB of the >>>8 result, and the luma level shift
    localparam ycc_sum_t  ROUND_C = 19'sd128;
    localparam ycc_wide_t Y_SHIFT = 10'sd128;

    // Sample saturation bounds, at intermediate width
    localparam ycc_wide_t WIDE_MAX = 10'sd127;
    localparam ycc_wide_t WIDE_MIN = -10'sd128;

    typedef enum logic [1:0] {
        SLOT_Y0 = 2'd0,
        SLOT_Y1 = 2'd1,
        SLOT_CB = 2'd2,
        SLOT_CR = 2'd3
    } ycc_slot_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } ycc_rgb_t;

    typedef struct packed {
        ycc_sample_t y0;
        ycc_sample_t y1;
        ycc_sample_t cb;
        ycc_sample_t cr;
    } ycc_result_t;

endpackage

// File: rtl/ycc_pixel_convert.sv
// One pixel's RGB -> unclamped {Y', Cb', Cr'}: registered coefficient sums,
// then combinational rounding and level shift. Sums hold while ld is low.
module ycc_pixel_convert
    import ycc_pkg::*;
(
    input  logic       clk,
    input  logic       ld,
    input  ycc_rgb_t   pix,
    output ycc_wide_t  y,
    output ycc_wide_t  cb,
    output ycc_wide_t  cr
);

    // Add half an LSB then floor-shift; the sum range keeps the result in 10 bits
    function automatic ycc_wide_t round_shift(input ycc_sum_t s);
        ycc_sum_t t;
        t = s + ROUND_C;
        return ycc_wide_t'(t >>> 8);
    endfunction

    ycc_sum_t r_s, g_s, b_s;
    ycc_sum_t ys_p1_d, cbs_p1_d, crs_p1_d;
    ycc_sum_t ys_p1_q, cbs_p1_q, crs_p1_q;

    assign r_s = ycc_sum_t'({11'd0, pix.r});
    assign g_s = ycc_sum_t'({11'd0, pix.g});
    assign b_s = ycc_sum_t'({11'd0, pix.b});

    // Stage 1: coefficient sums, loaded on launch and held otherwise
    always_comb begin
        ys_p1_d  = ys_p1_q;
        cbs_p1_d = cbs_p1_q;
        crs_p1_d = crs_p1_q;
        if (ld) begin
            ys_p1_d  = C_Y_R  * r_s + C_Y_G  * g_s + C_Y_B  * b_s;
            cbs_p1_d = C_CB_R * r_s + C_CB_G * g_s + C_CB_B * b_s;
            crs_p1_d = C_CR_R * r_s + C_CR_G * g_s + C_CR_B * b_s;
        end
    end

    // Stage 1 data registers (validity is tracked by the parent)
    always_ff @(posedge clk) begin
        ys_p1_q  <= ys_p1_d;
        cbs_p1_q <= cbs_p1_d;
        crs_p1_q <= crs_p1_d;
    end

    // Stage 2 arithmetic: chroma +128 offset and -128 level shift cancel
    assign y  = round_shift(ys_p1_q) - Y_SHIFT;
    assign cb = round_shift(cbs_p1_q);
    assign cr = round_shift(crs_p1_q);

endmodule

// File: rtl/ycc_sample_sender.sv
// Pairs RGB pixels, converts them, averages and clamps chroma, and emits the
// four tagged samples Y0, Y1, Cb, Cr of each pair on consecutive cycles.
module ycc_sample_sender
    import ycc_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    output logic signed [7:0] img_out,
    output logic [1:0]        state_Ycc,
    output logic              data_en
);

    function automatic ycc_sample_t sat_sample(input ycc_wide_t v);
        if (v > WIDE_MAX) return ycc_sample_t'(WIDE_MAX);
        if (v < WIDE_MIN) return ycc_sample_t'(WIDE_MIN);
        return ycc_sample_t'(v);
    endfunction

    // Floor average; the sum of two in-range chroma values fits 10 bits
    function automatic ycc_wide_t avg2(input ycc_wide_t a, input ycc_wide_t b);
        ycc_wide_t s;
        s = a + b;
        return s >>> 1;
    endfunction

    function automatic ycc_sample_t pick(input ycc_result_t r, input ycc_slot_e s);
        ycc_sample_t v;
        v = r.y0;
        case (s)
            SLOT_Y1: v = r.y1;
            SLOT_CB: v = r.cb;
            SLOT_CR: v = r.cr;
            default: v = r.y0;
        endcase
        return v;
    endfunction

    // Control state
    logic        in_cnt_q, in_cnt_d;
    logic        pair_full_q, pair_full_d;
    logic        vld_p1_q, vld_p1_d;
    logic        vld_p2_q, vld_p2_d;
    logic        vld_p3_q, vld_p3_d;
    ycc_slot_e   slot_p3_q, slot_p3_d;
    ycc_sample_t img_p3_q, img_p3_d;

    // Data state
    ycc_rgb_t    pix0_q, pix0_d;
    ycc_rgb_t    pix1_q, pix1_d;
    ycc_result_t res_p2_q, res_p2_d;
    ycc_result_t buf_p3_q, buf_p3_d;

    logic        accept, launch, adv_p1, emit_load;
    ycc_rgb_t    pix_in;
    ycc_wide_t   y0_w, cb0_w, cr0_w, y1_w, cb1_w, cr1_w;

    assign pix_in    = '{r: pix_r, g: pix_g, b: pix_b};
    assign pix_ready = !pair_full_q;
    assign accept    = pix_valid && pix_ready;
    // Emitter takes a result when idle or on its last slot, so pairs run back to back
    assign emit_load = vld_p2_q && (!vld_p3_q || slot_p3_q == SLOT_CR);
    assign adv_p1    = vld_p1_q && (!vld_p2_q || emit_load);
    assign launch    = pair_full_q && (!vld_p1_q || adv_p1);

    ycc_pixel_convert u_conv0 (
        .clk (sys_clk),
        .ld  (launch),
        .pix (pix0_q),
        .y   (y0_w),
        .cb  (cb0_w),
        .cr  (cr0_w)
    );

    ycc_pixel_convert u_conv1 (
        .clk (sys_clk),
        .ld  (launch),
        .pix (pix1_q),
        .y   (y1_w),
        .cb  (cb1_w),
        .cr  (cr1_w)
    );

    // Stage 0: input handshake and pair assembly; pix0 may be reloaded once the pair has launched
    always_comb begin
        in_cnt_d    = in_cnt_q;
        pair_full_d = pair_full_q;
        pix0_d      = pix0_q;
        pix1_d      = pix1_q;
        if (accept) begin
            in_cnt_d = !in_cnt_q;
            if (in_cnt_q) begin
                pix1_d      = pix_in;
                pair_full_d = 1'b1;
            end else begin
                pix0_d = pix_in;
            end
        end else if (launch) begin
            pair_full_d = 1'b0;
        end
    end

    // Stage 1/2 occupancy and the averaged, clamped result register
    always_comb begin
        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        res_p2_d = res_p2_q;
        if (launch)
            vld_p1_d = 1'b1;
        else if (adv_p1)
            vld_p1_d = 1'b0;
        if (adv_p1) begin
            vld_p2_d    = 1'b1;
            res_p2_d.y0 = sat_sample(y0_w);
            res_p2_d.y1 = sat_sample(y1_w);
            res_p2_d.cb = sat_sample(avg2(cb0_w, cb1_w));
            res_p2_d.cr = sat_sample(avg2(cr0_w, cr1_w));
        end else if (emit_load) begin
            vld_p2_d = 1'b0;
        end
    end

    // Stage 3: emitter walking slots Y0, Y1, Cb, Cr; outputs zero when idle
    always_comb begin
        vld_p3_d  = 1'b0;
        slot_p3_d = SLOT_Y0;
        img_p3_d  = '0;
        buf_p3_d  = buf_p3_q;
        if (emit_load) begin
            vld_p3_d  = 1'b1;
            slot_p3_d = SLOT_Y0;
            img_p3_d  = res_p2_q.y0;
            buf_p3_d  = res_p2_q;
        end else if (vld_p3_q && slot_p3_q != SLOT_CR) begin
            vld_p3_d  = 1'b1;
            slot_p3_d = ycc_slot_e'(slot_p3_q + 2'd1);
            img_p3_d  = pick(buf_p3_q, ycc_slot_e'(slot_p3_q + 2'd1));
        end
    end

    // Control registers, including the registered outputs, cleared by reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            in_cnt_q    <= 1'b0;
            pair_full_q <= 1'b0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            vld_p3_q    <= 1'b0;
            slot_p3_q   <= SLOT_Y0;
            img_p3_q    <= '0;
        end else begin
            in_cnt_q    <= in_cnt_d;
            pair_full_q <= pair_full_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            vld_p3_q    <= vld_p3_d;
            slot_p3_q   <= slot_p3_d;
            img_p3_q    <= img_p3_d;
        end
    end

    // Data registers, qualified by the valid flags above
    always_ff @(posedge sys_clk) begin
        pix0_q   <= pix0_d;
        pix1_q   <= pix1_d;
        res_p2_q <= res_p2_d;
        buf_p3_q <= buf_p3_d;
    end

    assign img_out   = img_p3_q;
    assign state_Ycc = slot_p3_q;
    assign data_en   = vld_p3_q;

endmodule
